// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//   Types and defaults used by the register file, the writeback arbiter and the
//   issue logic:
//     ADDR_W_DEF / DATA_W_DEF : default register address / data widths
//     reg_addr_t              : register address at the default width
//     wb_state_e              : writeback port state (IDLE, WRITE)
//     rr_next()               : round-robin pointer successor
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 8;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_e;

  // Next search start after requester `winner` was served: (winner+1) mod num_req.
  function automatic int rr_next(input int winner, input int num_req);
    return (winner + 1 >= num_req) ? 0 : winner + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Bundles the writeback requester bus and the register-file write port.
//   master : requesters / register file side (drives requests, stall)
//   slave  : the arbiter (drives ready, write port, pending mask)
//   Signals:
//     req_valid[NUM_REQ], req_addr[NUM_REQ*ADDR_W], req_data[NUM_REQ*DATA_W]
//     req_ready[NUM_REQ]  one-hot/zero grant
//     stall               blocks new grants
//     write_enable, write_addr, write_data, grant_id   register-file write beat
//     pending_mask[2**ADDR_W]                           register being written
//   Optional (WB_FORWARD_EN): fwd_addr1/2 in, fwd_hit1/2 and fwd_data1/2 out.
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      stall;
  logic                      write_enable;
  logic [ADDR_W-1:0]         write_addr;
  logic [DATA_W-1:0]         write_data;
  logic [ID_W-1:0]           grant_id;
  logic [(2**ADDR_W)-1:0]    pending_mask;
`ifdef WB_FORWARD_EN
  logic [ADDR_W-1:0]         fwd_addr1;
  logic [ADDR_W-1:0]         fwd_addr2;
  logic                      fwd_hit1;
  logic                      fwd_hit2;
  logic [DATA_W-1:0]         fwd_data1;
  logic [DATA_W-1:0]         fwd_data2;
`endif

  modport master (
    output req_valid, req_addr, req_data, stall,
`ifdef WB_FORWARD_EN
    output fwd_addr1, fwd_addr2,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    input  req_ready, write_enable, write_addr, write_data, grant_id, pending_mask
  );

  modport slave (
    input  req_valid, req_addr, req_data, stall,
`ifdef WB_FORWARD_EN
    input  fwd_addr1, fwd_addr2,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
    output req_ready, write_enable, write_addr, write_data, grant_id, pending_mask
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first set bit of `req` searching from
//   index `ptr` upward (mod NUM_REQ) wins when `en` is high.
//   Ports:
//     req[NUM_REQ]  request vector
//     ptr[ID_W]     search start index (0..NUM_REQ-1)
//     en            grant enable; grant is zero when low
//     grant         one-hot/zero grant vector
//     winner[ID_W]  index of the granted requester (valid when grant != 0)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner
);

  logic [2*NUM_REQ-1:0] req_rot;
  logic                 found;
  int                   pos;

  // Rotating a doubled copy puts requester ptr at bit 0, so a plain
  // lowest-bit-first scan implements the wrap-around search.
  always_comb begin
    req_rot = {req, req} >> ptr;
    found   = 1'b0;
    pos     = 0;
    winner  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        pos   = int'(ptr) + k;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        winner = ID_W'(pos);
      end
    end
    grant = (en && found) ? (NUM_REQ'(1) << winner) : '0;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port between NUM_REQ writeback
//   requesters. Round-robin grant with valid/ready handshake; the winning
//   request is staged for one cycle and then presented as a write beat.
//   pending_mask flags the register being written this cycle so issue logic
//   can stall dependent reads.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     bus (regfile_wb_arbiter_if.slave)
//       req_valid/req_addr/req_data in, req_ready out, stall in
//       write_enable/write_addr/write_data/grant_id out (registered)
//       pending_mask out
//   Configuration macro WB_FORWARD_EN: adds two forwarding compare ports that
//   expose the in-flight write to readers one cycle early.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG = 2 ** ADDR_W;

  logic [ID_W-1:0]    rr_ptr;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant_p0;
  logic [ID_W-1:0]    winner_p0;
  logic               xfer_p0;
  logic [ADDR_W-1:0]  sel_addr_p0;
  logic [DATA_W-1:0]  sel_data_p0;

  wb_state_e          state_p1;
  logic [ADDR_W-1:0]  wr_addr_p1;
  logic [DATA_W-1:0]  wr_data_p1;
  logic [ID_W-1:0]    wr_id_p1;
  logic               vld_p1;
  logic [NREG-1:0]    pend_p1;

  // ---- p0: arbitration and request select ----
  assign arb_en = !bus.stall && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .en     (arb_en),
    .grant  (grant_p0),
    .winner (winner_p0)
  );

  // Grant only ever covers a valid requester, so any grant bit is a transfer.
  assign xfer_p0       = |grant_p0;
  assign bus.req_ready = grant_p0;

  always_comb begin
    sel_addr_p0 = '0;
    sel_data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_p0 == ID_W'(i)) begin
        sel_addr_p0 = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data_p0 = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---- p1: one-deep staging register / write-port FSM ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1   <= IDLE;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      wr_id_p1   <= '0;
      rr_ptr     <= '0;
    end else if (xfer_p0) begin
      state_p1   <= WRITE;
      wr_addr_p1 <= sel_addr_p0;
      wr_data_p1 <= sel_data_p0;
      wr_id_p1   <= winner_p0;
      rr_ptr     <= ID_W'(rr_next(int'(winner_p0), NUM_REQ));
    end else begin
      state_p1   <= IDLE;
    end
  end

  // A beat staged just before reset is suppressed here so the register file
  // never captures it.
  assign vld_p1 = (state_p1 == WRITE) && !reset;

  always_comb begin
    pend_p1 = '0;
    for (int r = 0; r < NREG; r++) begin
      pend_p1[r] = vld_p1 && (wr_addr_p1 == ADDR_W'(r));
    end
  end

  assign bus.write_enable = vld_p1;
  assign bus.write_addr   = wr_addr_p1;
  assign bus.write_data   = wr_data_p1;
  assign bus.grant_id     = wr_id_p1;
  assign bus.pending_mask = pend_p1;

`ifdef WB_FORWARD_EN
  // Readers of the register being written see the value it holds next cycle.
  assign bus.fwd_hit1  = vld_p1 && (wr_addr_p1 == bus.fwd_addr1);
  assign bus.fwd_hit2  = vld_p1 && (wr_addr_p1 == bus.fwd_addr2);
  assign bus.fwd_data1 = wr_data_p1;
  assign bus.fwd_data2 = wr_data_p1;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int AW = 2;
  localparam int DW = 8;

  logic clk;
  logic reset;
  logic rf_clr;
  logic [DW-1:0] rf [4];

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file behind the write port.
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (bus.write_enable) begin
      rf[bus.write_addr] <= bus.write_data;
    end
  end

`ifdef WB_FORWARD_EN
  initial begin
    bus.fwd_addr1 = '0;
    bus.fwd_addr2 = '0;
  end
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic [1:0] v,
                       input logic [1:0] a0, input logic [7:0] d0,
                       input logic [1:0] a1, input logic [7:0] d1);
    reset         = rst;
    bus.stall     = st;
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
  endtask

  // Compare all observable outputs against expectations for this cycle.
  task automatic check_outs(input string tag, input logic [1:0] rdy, input logic we,
                            input logic [1:0] wa, input logic [7:0] wd,
                            input logic gid, input logic [3:0] pend);
    chk({tag, " ready"}, 32'(bus.req_ready), 32'(rdy));
    chk({tag, " we"}, 32'(bus.write_enable), 32'(we));
    chk({tag, " pend"}, 32'(bus.pending_mask), 32'(pend));
    if (we) begin
      chk({tag, " waddr"}, 32'(bus.write_addr), 32'(wa));
      chk({tag, " wdata"}, 32'(bus.write_data), 32'(wd));
      chk({tag, " gid"}, 32'(bus.grant_id), 32'(gid));
    end
  endtask

  typedef struct {
    logic       rst;
    logic       stall;
    logic [1:0] valid;
    logic [1:0] a0;
    logic [7:0] d0;
    logic [1:0] a1;
    logic [7:0] d1;
    logic [1:0] ready;
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       gid;
    logic [3:0] pend;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int rst, input int st, input int v,
                              input int a0, input int d0, input int a1, input int d1,
                              input int rdy, input int we, input int wa, input int wd,
                              input int gid, input int pend);
    vec_t r;
    r.rst = 1'(rst);  r.stall = 1'(st);  r.valid = 2'(v);
    r.a0 = 2'(a0);    r.d0 = 8'(d0);     r.a1 = 2'(a1);   r.d1 = 8'(d1);
    r.ready = 2'(rdy); r.we = 1'(we);    r.waddr = 2'(wa); r.wdata = 8'(wd);
    r.gid = 1'(gid);  r.pend = 4'(pend);
    return r;
  endfunction

  // Behavioural reference state for the random phase.
  int         m_ptr;
  logic       m_we;
  logic [1:0] m_addr;
  logic [7:0] m_data;
  int         m_id;
  logic [7:0] m_rf [4];
  logic [1:0] rv;
  logic [1:0] ra [2];
  logic [7:0] rd [2];
  logic [1:0] xf;

  initial begin
    drive(1'b1, 1'b0, 2'b11, 2'd0, 8'd0, 2'd0, 8'd0);
    rf_clr = 1'b1;

    // rst st  v    a0 d0  a1 d1   rdy we wa wd gid pend
    tbl.push_back(mk(1, 0, 2'b11, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 0, 2'b11, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 0, 2'b11, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 1, 42, 0, 0,  1, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0,  0, 0,  0, 1, 1, 42, 0, 4'b0010));
    tbl.push_back(mk(1, 0, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 0, 2'b11, 2, 10, 3, 20, 1, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 0, 2'b11, 2, 10, 3, 20, 2, 1, 2, 10, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 2'b11, 2, 10, 3, 20, 1, 1, 3, 20, 1, 4'b1000));
    tbl.push_back(mk(0, 0, 2'b11, 2, 10, 3, 20, 2, 1, 2, 10, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0,  0, 0,  0, 1, 3, 20, 1, 4'b1000));
    tbl.push_back(mk(0, 0, 2'b11, 1, 5,  1, 9,  1, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 0, 2'b10, 1, 5,  1, 9,  2, 1, 1, 5,  0, 4'b0010));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0,  0, 0,  0, 1, 1, 9,  1, 4'b0010));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 0, 77, 0, 0,  1, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 2, 33, 0, 0,  0, 1, 0, 77, 0, 4'b0001));
    tbl.push_back(mk(0, 1, 2'b01, 2, 33, 0, 0,  0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 2, 33, 0, 0,  0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 2'b01, 2, 33, 0, 0,  0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 0, 2'b01, 2, 33, 0, 0,  1, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0,  0, 0,  0, 1, 2, 33, 0, 4'b0100));

    @(posedge clk); #1;
    rf_clr = 1'b0;

    // ---- table-driven directed vectors ----
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].valid, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), tbl[i].ready, tbl[i].we, tbl[i].waddr,
                 tbl[i].wdata, tbl[i].gid, tbl[i].pend);
      @(posedge clk); #1;
    end
    chk("rf R0", 32'(rf[0]), 32'd77);
    chk("rf R1 last writer wins", 32'(rf[1]), 32'd9);
    chk("rf R2", 32'(rf[2]), 32'd33);
    chk("rf R3", 32'(rf[3]), 32'd20);

    // ---- reset in the cycle after a transfer drops the staged write ----
    drive(1'b0, 1'b0, 2'b00, 2'd0, 8'd0, 2'd0, 8'd0);
    rf_clr = 1'b1;
    @(posedge clk); #1;
    rf_clr = 1'b0;
    drive(1'b0, 1'b0, 2'b10, 2'd0, 8'd0, 2'd3, 8'd55);
    @(negedge clk);
    chk("rst6 ready", 32'(bus.req_ready), 32'd2);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'b00, 2'd0, 8'd0, 2'd0, 8'd0);
    @(negedge clk);
    chk("rst6 we during reset", 32'(bus.write_enable), 32'd0);
    chk("rst6 pend during reset", 32'(bus.pending_mask), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 2'd0, 8'd0, 2'd0, 8'd0);
    @(negedge clk);
    chk("rst6 we after reset", 32'(bus.write_enable), 32'd0);
    chk("rst6 waddr reset", 32'(bus.write_addr), 32'd0);
    chk("rst6 wdata reset", 32'(bus.write_data), 32'd0);
    chk("rst6 gid reset", 32'(bus.grant_id), 32'd0);
    @(posedge clk); #1;
    chk("rst6 R3 unchanged", 32'(rf[3]), 32'd0);

    // ---- randomized traffic against the reference model ----
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    rf_clr = 1'b1;
    m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_id = 0;
    rv = '0; xf = '0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rd[i] = '0; end
    drive(1'b1, 1'b0, 2'b00, 2'd0, 8'd0, 2'd0, 8'd0);
    @(posedge clk); #1;
    rf_clr = 1'b0;

    for (int cyc = 0; cyc < 500; cyc++) begin
      logic       r_rst, r_st, ewe, found;
      logic [1:0] erdy;
      int         w;
      r_rst = ($urandom_range(0, 24) == 0);
      r_st  = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (rv[i] && !xf[i]) begin
          // Waiting requester keeps addr/data; occasionally withdraws.
          if ($urandom_range(0, 9) == 0) rv[i] = 1'b0;
        end else begin
          rv[i] = 1'($urandom_range(0, 1));
          ra[i] = 2'($urandom_range(0, 3));
          rd[i] = 8'($urandom_range(0, 255));
        end
      end
      drive(r_rst, r_st, rv, ra[0], rd[0], ra[1], rd[1]);

      erdy = '0; found = 1'b0; w = 0;
      if (!r_rst && !r_st) begin
        for (int k = 0; k < N; k++) begin
          if (!found && rv[(m_ptr + k) % N]) begin
            found = 1'b1;
            w = (m_ptr + k) % N;
          end
        end
        if (found) erdy[w] = 1'b1;
      end
      ewe = m_we && !r_rst;

      @(negedge clk);
      check_outs($sformatf("rnd%0d", cyc), erdy, ewe, m_addr, m_data, 1'(m_id),
                 ewe ? 4'(4'b0001 << m_addr) : 4'b0000);
      @(posedge clk);
      if (ewe) m_rf[m_addr] = m_data;
      if (r_rst) begin
        m_ptr = 0;
        m_we  = 1'b0;
      end else if (found) begin
        m_we   = 1'b1;
        m_addr = ra[w];
        m_data = rd[w];
        m_id   = w;
        m_ptr  = (w + 1) % N;
      end else begin
        m_we = 1'b0;
      end
      xf = erdy;
      #1;
    end

    drive(1'b0, 1'b0, 2'b00, 2'd0, 8'd0, 2'd0, 8'd0);
    @(posedge clk);
    if (m_we) m_rf[m_addr] = m_data;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rnd rf R%0d", i), 32'(rf[i]), 32'(m_rf[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
